dds_bram_sequencer: RTL and testbench
=====================================

# dds_bram_sequencer

Phase-accumulator controller that generates the 48-bit phase stream and BRAM address for a DDS waveform-table channel. It accepts new frequency (increment) and phase-offset settings through a valid/ready handshake and starts and stops the channel. It applies updates phase-continuously at accumulator wrap-around, so BRAM playback never glitches mid-period. It sits between the register/config interface and the BRAM waveform lookup.

## Interface
Parameters:
- COUNTER_SIZE, 13: BRAM address width; address = top COUNTER_SIZE bits of the phase.

Ports:
- clk  in  1  single clock for the block.
- areset  in  1  asynchronous, active-high reset.
- run  in  1  level; 1 = channel running, 0 = stopped.
- cfg_incr  in  48  new phase increment.
- cfg_offset  in  48  new phase offset.
- cfg_valid  in  1  cfg_incr/cfg_offset are valid.
- cfg_ready  out  1  block accepts the config this cycle.
- m_axis_tdata_phase  out  48  phase = acc + offset (mod 2^48).
- m_axis_tvalid_phase  out  1  phase word valid.
- addr  out  COUNTER_SIZE  phase[47:48-COUNTER_SIZE], aligned with tdata.
- wrap  out  1  one-cycle pulse when the accumulator carried out.
- update_applied  out  1  one-cycle pulse when a new incr/offset takes effect.

## Operation
- Registers: acc[47:0], incr[47:0], offset[47:0], shadow incr/offset, state.
- States: IDLE, RUN, ARMED (update pending).
- Handshake: a transfer occurs when cfg_valid && cfg_ready. cfg_ready is 1 in IDLE and RUN and 0 in ARMED.
- IDLE:
  - tvalid = 0 and acc holds.
  - A transfer writes incr and offset directly and pulses update_applied.
  - run = 1 sets acc <= 0 and moves to RUN.
- RUN:
  - Each edge: acc <= acc + incr (mod 2^48); wrap <= carry out of the 49-bit sum.
  - Output registers: tdata <= acc + offset; addr <= top bits of the same sum; tvalid <= 1.
  - A transfer captures the config into the shadow and moves to ARMED.
- ARMED:
  - Accumulates exactly as RUN, using the old incr and offset.
  - On the edge whose sum carries, acc takes the old-incr result, incr and offset load from the shadow, update_applied pulses, and the state returns to RUN.
- Stop: run = 0 in RUN or ARMED moves to IDLE. In ARMED the shadow is applied on that same edge and update_applied pulses. tvalid drops on the next edge.
- Boundaries:
  - A transfer on the same edge as a wrap in RUN is applied at the next wrap, not the current one.
  - incr = 0 in ARMED never wraps; the update stays pending until a stop.
  - Adder overflow is silently modulo 2^48.
  - Asserting areset mid-operation discards any pending update.

## Timing
- Reset values: state IDLE; acc, incr, offset, shadow, tdata and addr are all 0; tvalid, wrap and update_applied are 0; cfg_ready is 1.
- run is sampled high on edge E0 (acc <= 0). On E1, tvalid becomes 1 with tdata = offset. On E(k+1), tdata = offset + k*incr.
- Phase latency: one register stage from acc to tdata/addr.
- wrap is aligned with the output word computed from the post-wrap acc.
- After a stop, tvalid is 0 one edge after run is sampled low.
- cfg_ready is a registered function of state (no combinational path from cfg_valid).

## Configuration
- DDS_SEQ_WRAP_SYNC_EN defined: ARMED behaviour as described; updates in RUN wait for the wrap.
- DDS_SEQ_WRAP_SYNC_EN undefined:
  - ARMED state is removed and cfg_ready is constantly 1.
  - A transfer in RUN loads incr and offset on the handshake edge.
  - The next acc sum uses the new incr, and update_applied pulses.

## Structure
- Shared package dds_pkg: PHASE_W = 48, the state enum (IDLE/RUN/ARMED), and a phase_t typedef.
- Sub-module dds_phase_acc: 48-bit accumulator with carry out and offset adder, driving tdata and addr. The FSM and handshake logic stay in the top module.

## Test plan
- Reset, then incr = 2^46, offset = 0, run = 1: tvalid rises on the second edge. addr cycles 0, 2048, 4096, 6144, 0. wrap pulses every 4th word.
- While running, transfer incr = 2^45 one cycle after a wrap (macro on): cfg_ready stays 0 until the next wrap. The new step size of 1024 addresses starts exactly after that wrap, and update_applied pulses once.
- Same stimulus with the macro off: cfg_ready stays 1. The step changes on the cycle after the handshake.
- offset = 2^47 in IDLE, then run: the first addr is 4096, and update_applied pulses at the IDLE write.
- Transfer with incr = 0 in ARMED, then run = 0: update applied on the stop edge; tvalid is 0 on the next edge.
- Assert areset while ARMED: all outputs return to reset values and the pending shadow is discarded (the old incr is not replaced).

Source files
------------

// File: rtl/dds_pkg.sv
// Shared types for the DDS BRAM sequencer. DDS_SEQ_WRAP_SYNC_EN adds the ARMED state
// used to defer config updates to the next accumulator wrap.
package dds_pkg;

    localparam int unsigned PHASE_W = 48;

    typedef logic [PHASE_W-1:0] phase_t;

`ifdef DDS_SEQ_WRAP_SYNC_EN
    typedef enum logic [1:0] {StIdle, StRun, StArmed} state_e;
`else
    typedef enum logic [0:0] {StIdle, StRun} state_e;
`endif

    // 49-bit sum so the MSB is the accumulator carry out.
    function automatic logic [PHASE_W:0] phase_add(input phase_t a, input phase_t b);
        return {1'b0, a} + {1'b0, b};
    endfunction

endpackage

// File: rtl/dds_bram_sequencer_if.sv
// Config handshake and phase-stream bundle for dds_bram_sequencer
// (DDS_SEQ_WRAP_SYNC_EN only changes how the slave drives cfg_ready).
interface dds_bram_sequencer_if #(
    parameter int unsigned COUNTER_SIZE = 13
);
    import dds_pkg::*;

    phase_t                  cfg_incr;
    phase_t                  cfg_offset;
    logic                    cfg_valid;
    logic                    cfg_ready;
    phase_t                  m_axis_tdata_phase;
    logic                    m_axis_tvalid_phase;
    logic [COUNTER_SIZE-1:0] addr;
    logic                    wrap;
    logic                    update_applied;

    modport master (
        output cfg_incr, cfg_offset, cfg_valid,
        input  cfg_ready, m_axis_tdata_phase, m_axis_tvalid_phase, addr, wrap, update_applied
    );

    modport slave (
        input  cfg_incr, cfg_offset, cfg_valid,
        output cfg_ready, m_axis_tdata_phase, m_axis_tvalid_phase, addr, wrap, update_applied
    );

endinterface

// File: rtl/dds_phase_acc.sv
// 48-bit phase accumulator with offset adder and registered phase/address/wrap outputs.
// Behaviour is identical with or without DDS_SEQ_WRAP_SYNC_EN.
module dds_phase_acc
    import dds_pkg::*;
#(
    parameter int unsigned COUNTER_SIZE = 13
) (
    input  logic                    clk,
    input  logic                    areset,
    input  logic                    clear_i,
    input  logic                    advance_i,
    input  phase_t                  incr_i,
    input  phase_t                  offset_i,
    output logic                    carry_o,
    output phase_t                  tdata_o,
    output logic [COUNTER_SIZE-1:0] addr_o,
    output logic                    wrap_o
);

    phase_t                  acc_q;
    logic                    acc_wrapped_q;
    phase_t                  tdata_q;
    logic [COUNTER_SIZE-1:0] addr_q;
    logic                    wrap_q;
    logic [PHASE_W:0]        sum;
    phase_t                  phase;

    assign sum     = phase_add(acc_q, incr_i);
    assign carry_o = sum[PHASE_W];
    assign phase   = acc_q + offset_i;

    // acc_wrapped_q tags acc as post-wrap so wrap lines up with the word built from it.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            acc_q         <= '0;
            acc_wrapped_q <= 1'b0;
            tdata_q       <= '0;
            addr_q        <= '0;
            wrap_q        <= 1'b0;
        end else if (clear_i) begin
            acc_q         <= '0;
            acc_wrapped_q <= 1'b0;
            wrap_q        <= 1'b0;
        end else if (advance_i) begin
            acc_q         <= sum[PHASE_W-1:0];
            acc_wrapped_q <= carry_o;
            tdata_q       <= phase;
            addr_q        <= phase[PHASE_W-1 -: COUNTER_SIZE];
            wrap_q        <= acc_wrapped_q;
        end else begin
            wrap_q        <= 1'b0;
        end
    end

    assign tdata_o = tdata_q;
    assign addr_o  = addr_q;
    assign wrap_o  = wrap_q;

endmodule

// File: rtl/dds_bram_sequencer.sv
// DDS channel controller: run/stop FSM and config handshake around dds_phase_acc.
// DDS_SEQ_WRAP_SYNC_EN defers RUN-state updates to the next accumulator wrap.
module dds_bram_sequencer
    import dds_pkg::*;
#(
    parameter int unsigned COUNTER_SIZE = 13
) (
    input  logic               clk,
    input  logic               areset,
    input  logic               run,
    dds_bram_sequencer_if.slave bus
);

    state_e state_q;
    phase_t incr_q;
    phase_t offset_q;
    logic   tvalid_q;
    logic   applied_q;
    logic   acc_carry;
    logic   advance;
    logic   clear;
    logic   xfer;

    assign xfer    = bus.cfg_valid && bus.cfg_ready;
    assign advance = (state_q != StIdle);
    assign clear   = (state_q == StIdle) && run;

`ifdef DDS_SEQ_WRAP_SYNC_EN
    phase_t shadow_incr_q;
    phase_t shadow_offset_q;
    logic   cfg_ready_q;

    assign bus.cfg_ready = cfg_ready_q;
`else
    logic unused_carry;

    assign unused_carry  = acc_carry;
    assign bus.cfg_ready = 1'b1;
`endif

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state_q         <= StIdle;
            incr_q          <= '0;
            offset_q        <= '0;
            tvalid_q        <= 1'b0;
            applied_q       <= 1'b0;
`ifdef DDS_SEQ_WRAP_SYNC_EN
            shadow_incr_q   <= '0;
            shadow_offset_q <= '0;
            cfg_ready_q     <= 1'b1;
`endif
        end else begin
            applied_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    tvalid_q <= 1'b0;
                    if (xfer) begin
                        incr_q    <= bus.cfg_incr;
                        offset_q  <= bus.cfg_offset;
                        applied_q <= 1'b1;
                    end
                    if (run) begin
                        state_q <= StRun;
                    end
                end
                StRun: begin
                    tvalid_q <= 1'b1;
                    if (!run) begin
                        state_q <= StIdle;
                    end
`ifdef DDS_SEQ_WRAP_SYNC_EN
                    // A stop edge applies directly since there is no wrap left to wait for.
                    if (xfer && run) begin
                        shadow_incr_q   <= bus.cfg_incr;
                        shadow_offset_q <= bus.cfg_offset;
                        cfg_ready_q     <= 1'b0;
                        state_q         <= StArmed;
                    end else if (xfer) begin
                        incr_q    <= bus.cfg_incr;
                        offset_q  <= bus.cfg_offset;
                        applied_q <= 1'b1;
                    end
`else
                    if (xfer) begin
                        incr_q    <= bus.cfg_incr;
                        offset_q  <= bus.cfg_offset;
                        applied_q <= 1'b1;
                    end
`endif
                end
`ifdef DDS_SEQ_WRAP_SYNC_EN
                StArmed: begin
                    tvalid_q <= 1'b1;
                    if (!run || acc_carry) begin
                        incr_q      <= shadow_incr_q;
                        offset_q    <= shadow_offset_q;
                        applied_q   <= 1'b1;
                        cfg_ready_q <= 1'b1;
                        state_q     <= run ? StRun : StIdle;
                    end
                end
`endif
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    dds_phase_acc #(
        .COUNTER_SIZE(COUNTER_SIZE)
    ) u_phase_acc (
        .clk      (clk),
        .areset   (areset),
        .clear_i  (clear),
        .advance_i(advance),
        .incr_i   (incr_q),
        .offset_i (offset_q),
        .carry_o  (acc_carry),
        .tdata_o  (bus.m_axis_tdata_phase),
        .addr_o   (bus.addr),
        .wrap_o   (bus.wrap)
    );

    assign bus.m_axis_tvalid_phase = tvalid_q;
    assign bus.update_applied      = applied_q;

endmodule

// File: tb/tb_dds_bram_sequencer.sv
// Directed bench for dds_bram_sequencer; expectations follow DDS_SEQ_WRAP_SYNC_EN when set.
module tb_dds_bram_sequencer;
    import dds_pkg::*;

    localparam phase_t P45 = 48'h2000_0000_0000;
    localparam phase_t P46 = 48'h4000_0000_0000;
    localparam phase_t P47 = 48'h8000_0000_0000;

    logic clk = 1'b0;
    logic areset;
    logic run;
    int   tests_run    = 0;
    int   tests_failed = 0;

    dds_bram_sequencer_if #(.COUNTER_SIZE(13)) bus ();

    dds_bram_sequencer #(
        .COUNTER_SIZE(13)
    ) dut (
        .clk   (clk),
        .areset(areset),
        .run   (run),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Outputs are sampled 1 time unit after the active edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        areset         = 1'b1;
        run            = 1'b0;
        bus.cfg_valid  = 1'b0;
        bus.cfg_incr   = '0;
        bus.cfg_offset = '0;
        tick();
        tick();
        areset = 1'b0;
    endtask

    task automatic cfg_write(input phase_t incr, input phase_t offset);
        bus.cfg_incr   = incr;
        bus.cfg_offset = offset;
        bus.cfg_valid  = 1'b1;
        tick();
        bus.cfg_valid  = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        tests_run++;
        if (bus.m_axis_tvalid_phase !== 1'b0 || bus.wrap !== 1'b0 || bus.update_applied !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_flags: tvalid/wrap/upd got %b%b%b expected 000",
                     bus.m_axis_tvalid_phase, bus.wrap, bus.update_applied);
        end
        tests_run++;
        if (bus.m_axis_tdata_phase !== 48'd0 || bus.addr !== 13'd0) begin
            tests_failed++;
            $display("FAIL reset_data: tdata %0h addr %0d expected 0 0",
                     bus.m_axis_tdata_phase, bus.addr);
        end
        tests_run++;
        if (bus.cfg_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_ready: got %b expected 1", bus.cfg_ready);
        end
    endtask

    task automatic test_basic();
        int   exp_addr[9] = '{0, 2048, 4096, 6144, 0, 2048, 4096, 6144, 0};
        logic exp_wrap[9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        do_reset();
        cfg_write(P46, '0);
        tests_run++;
        if (bus.update_applied !== 1'b1) begin
            tests_failed++;
            $display("FAIL basic_idle_upd: got %b expected 1", bus.update_applied);
        end
        run = 1'b1;
        tick();
        tests_run++;
        if (bus.m_axis_tvalid_phase !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic_tvalid_e0: got %b expected 0", bus.m_axis_tvalid_phase);
        end
        for (int k = 0; k < 9; k++) begin
            tick();
            tests_run++;
            if (bus.m_axis_tvalid_phase !== 1'b1 || bus.addr !== 13'(exp_addr[k])
                || bus.wrap !== exp_wrap[k]) begin
                tests_failed++;
                $display("FAIL basic_word%0d: tvalid %b addr %0d wrap %b expected 1 %0d %b",
                         k, bus.m_axis_tvalid_phase, bus.addr, bus.wrap, exp_addr[k], exp_wrap[k]);
            end
        end
    endtask

    task automatic test_update();
        int upd_count;
`ifdef DDS_SEQ_WRAP_SYNC_EN
        int   exp_addr[6] = '{4096, 6144, 0, 1024, 2048, 3072};
        logic exp_rdy[6]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        logic exp_upd[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        logic exp_wrap[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
`else
        int   exp_addr[6] = '{4096, 5120, 6144, 7168, 0, 1024};
        logic exp_rdy[6]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        logic exp_upd[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        logic exp_wrap[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
`endif
        do_reset();
        cfg_write(P46, '0);
        run = 1'b1;
        tick();
        for (int k = 0; k < 5; k++) tick();
        tests_run++;
        if (bus.wrap !== 1'b1 || bus.addr !== 13'd0) begin
            tests_failed++;
            $display("FAIL upd_prewrap: wrap %b addr %0d expected 1 0", bus.wrap, bus.addr);
        end
        bus.cfg_incr  = P45;
        bus.cfg_valid = 1'b1;
        tick();
        bus.cfg_valid = 1'b0;
        upd_count = 0;
        tests_run++;
`ifdef DDS_SEQ_WRAP_SYNC_EN
        if (bus.cfg_ready !== 1'b0 || bus.update_applied !== 1'b0 || bus.addr !== 13'd2048) begin
            tests_failed++;
            $display("FAIL upd_handshake: ready %b upd %b addr %0d expected 0 0 2048",
                     bus.cfg_ready, bus.update_applied, bus.addr);
        end
`else
        if (bus.cfg_ready !== 1'b1 || bus.update_applied !== 1'b1 || bus.addr !== 13'd2048) begin
            tests_failed++;
            $display("FAIL upd_handshake: ready %b upd %b addr %0d expected 1 1 2048",
                     bus.cfg_ready, bus.update_applied, bus.addr);
        end
`endif
        for (int k = 0; k < 6; k++) begin
            tick();
            if (bus.update_applied === 1'b1) upd_count++;
            tests_run++;
            if (bus.addr !== 13'(exp_addr[k]) || bus.cfg_ready !== exp_rdy[k]
                || bus.update_applied !== exp_upd[k] || bus.wrap !== exp_wrap[k]) begin
                tests_failed++;
                $display("FAIL upd_step%0d: addr %0d rdy %b upd %b wrap %b expected %0d %b %b %b",
                         k, bus.addr, bus.cfg_ready, bus.update_applied, bus.wrap,
                         exp_addr[k], exp_rdy[k], exp_upd[k], exp_wrap[k]);
            end
        end
        tests_run++;
`ifdef DDS_SEQ_WRAP_SYNC_EN
        if (upd_count !== 1) begin
            tests_failed++;
            $display("FAIL upd_once: pulses %0d expected 1", upd_count);
        end
`else
        if (upd_count !== 0) begin
            tests_failed++;
            $display("FAIL upd_once: later pulses %0d expected 0", upd_count);
        end
`endif
    endtask

    task automatic test_offset();
        do_reset();
        cfg_write(P46, P47);
        tests_run++;
        if (bus.update_applied !== 1'b1) begin
            tests_failed++;
            $display("FAIL offset_upd: got %b expected 1", bus.update_applied);
        end
        run = 1'b1;
        tick();
        tick();
        tests_run++;
        if (bus.addr !== 13'd4096 || bus.m_axis_tdata_phase !== P47) begin
            tests_failed++;
            $display("FAIL offset_first: addr %0d tdata %0h expected 4096 %0h",
                     bus.addr, bus.m_axis_tdata_phase, P47);
        end
        tick();
        tests_run++;
        if (bus.addr !== 13'd6144 || bus.m_axis_tdata_phase !== (P47 | P46)) begin
            tests_failed++;
            $display("FAIL offset_second: addr %0d tdata %0h expected 6144 %0h",
                     bus.addr, bus.m_axis_tdata_phase, P47 | P46);
        end
    endtask

    task automatic test_armed_stop();
        do_reset();
        cfg_write('0, '0);
        run = 1'b1;
        tick();
        tick();
        bus.cfg_incr  = P46;
        bus.cfg_valid = 1'b1;
        tick();
        bus.cfg_valid = 1'b0;
`ifdef DDS_SEQ_WRAP_SYNC_EN
        for (int k = 0; k < 4; k++) begin
            tick();
            tests_run++;
            if (bus.cfg_ready !== 1'b0 || bus.update_applied !== 1'b0 || bus.wrap !== 1'b0
                || bus.addr !== 13'd0) begin
                tests_failed++;
                $display("FAIL stop_pending%0d: rdy %b upd %b wrap %b addr %0d expected 0 0 0 0",
                         k, bus.cfg_ready, bus.update_applied, bus.wrap, bus.addr);
            end
        end
`else
        tests_run++;
        if (bus.update_applied !== 1'b1) begin
            tests_failed++;
            $display("FAIL stop_direct_upd: got %b expected 1", bus.update_applied);
        end
        tick();
        tick();
        tests_run++;
        if (bus.addr !== 13'd2048) begin
            tests_failed++;
            $display("FAIL stop_direct_step: addr %0d expected 2048", bus.addr);
        end
`endif
        run = 1'b0;
        tick();
        tests_run++;
`ifdef DDS_SEQ_WRAP_SYNC_EN
        if (bus.update_applied !== 1'b1 || bus.m_axis_tvalid_phase !== 1'b1
            || bus.cfg_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL stop_edge: upd %b tvalid %b rdy %b expected 1 1 1",
                     bus.update_applied, bus.m_axis_tvalid_phase, bus.cfg_ready);
        end
`else
        if (bus.update_applied !== 1'b0 || bus.m_axis_tvalid_phase !== 1'b1) begin
            tests_failed++;
            $display("FAIL stop_edge: upd %b tvalid %b expected 0 1",
                     bus.update_applied, bus.m_axis_tvalid_phase);
        end
`endif
        tick();
        tests_run++;
        if (bus.m_axis_tvalid_phase !== 1'b0 || bus.update_applied !== 1'b0) begin
            tests_failed++;
            $display("FAIL stop_after: tvalid %b upd %b expected 0 0",
                     bus.m_axis_tvalid_phase, bus.update_applied);
        end
        run = 1'b1;
        tick();
        tick();
        tick();
        tests_run++;
        if (bus.addr !== 13'd2048) begin
            tests_failed++;
            $display("FAIL stop_newincr: addr %0d expected 2048", bus.addr);
        end
    endtask

    task automatic test_areset_armed();
        do_reset();
        cfg_write(P46, '0);
        run = 1'b1;
        tick();
        tick();
        tick();
        bus.cfg_incr  = P45;
        bus.cfg_valid = 1'b1;
        tick();
        bus.cfg_valid = 1'b0;
`ifdef DDS_SEQ_WRAP_SYNC_EN
        tests_run++;
        if (bus.cfg_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL areset_armed_pre: rdy %b expected 0", bus.cfg_ready);
        end
`endif
        #2;
        areset = 1'b1;
        #1;
        tests_run++;
        if (bus.m_axis_tvalid_phase !== 1'b0 || bus.wrap !== 1'b0 || bus.update_applied !== 1'b0
            || bus.cfg_ready !== 1'b1 || bus.addr !== 13'd0 || bus.m_axis_tdata_phase !== 48'd0) begin
            tests_failed++;
            $display("FAIL areset_outputs: tv %b wr %b up %b rdy %b addr %0d tdata %0h expected 0 0 0 1 0 0",
                     bus.m_axis_tvalid_phase, bus.wrap, bus.update_applied, bus.cfg_ready,
                     bus.addr, bus.m_axis_tdata_phase);
        end
        @(negedge clk);
        areset = 1'b0;
        tick();
        tick();
        tick();
        tests_run++;
        if (bus.m_axis_tvalid_phase !== 1'b1 || bus.addr !== 13'd0 || bus.update_applied !== 1'b0) begin
            tests_failed++;
            $display("FAIL areset_discard: tvalid %b addr %0d upd %b expected 1 0 0",
                     bus.m_axis_tvalid_phase, bus.addr, bus.update_applied);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_update();
        test_offset();
        test_armed_stop();
        test_areset_armed();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
